// File: rtl/lls_pkg.sv
// Shared types and constants for the left logical shifter slice.
package lls_pkg;

  localparam int LLS_WIDTH   = 32;
  localparam int LLS_SHAMT_W = 5;

  typedef logic [LLS_WIDTH-1:0]   lls_word_t;
  typedef logic [LLS_SHAMT_W-1:0] lls_shamt_t;

endpackage : lls_pkg

// File: rtl/lls_stage.sv
// One level of the logarithmic barrel network: shifts left by SHIFT when
// sel is set, otherwise passes the word through unchanged.
module lls_stage
  import lls_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic      sel,
  input  lls_word_t d,
  output lls_word_t q
);

  // Conditional fixed-distance left shift with zero fill.
  always_comb begin
    q = d;
    if (sel) begin
      q = d << SHIFT;
    end else begin
      q = d;
    end
  end

endmodule : lls_stage

// File: rtl/left_l_shifter.sv
// 32-bit left logical shifter, one register stage (latency 1).
// Optional build macro LLS_SHAMT_MASK_EN: when defined, only B[4:0] is
// used as the shift amount (RV32 SLL semantics); when undefined, any
// amount of 32 or more yields zero (full-width A << B semantics).
module left_l_shifter
  import lls_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        out_valid
);

  lls_word_t  stage_s [0:LLS_SHAMT_W];
  lls_shamt_t shamt_s;
  lls_word_t  net_s;
  lls_word_t  s_r;
  logic       valid_r;

  assign shamt_s    = B[LLS_SHAMT_W-1:0];
  assign stage_s[0] = A;

  // Five barrel levels, level k shifting by 2^k under control of B[k].
  for (genvar k = 0; k < LLS_SHAMT_W; k++) begin : g_level
    lls_stage #(
      .SHIFT(1 << k)
    ) u_stage (
      .sel(shamt_s[k]),
      .d  (stage_s[k]),
      .q  (stage_s[k+1])
    );
  end

`ifdef LLS_SHAMT_MASK_EN
  // Upper amount bits are intentionally ignored in the masked build.
  logic unused_hi_s;
  assign unused_hi_s = |B[31:LLS_SHAMT_W];

  // Masked build: the 5-bit network result is the final answer.
  always_comb begin
    net_s = stage_s[LLS_SHAMT_W];
  end
`else
  // Full-width build: any amount >= 32 shifts every bit out.
  always_comb begin
    net_s = 32'h0000_0000;
    if (|B[31:LLS_SHAMT_W]) begin
      net_s = 32'h0000_0000;
    end else begin
      net_s = stage_s[LLS_SHAMT_W];
    end
  end
`endif

  // Result register: loads only on a valid capture, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r <= 32'h0000_0000;
    end else if (in_valid) begin
      s_r <= net_s;
    end else begin
      s_r <= s_r;
    end
  end

  // Valid strobe travels one cycle behind in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= in_valid;
    end
  end

  assign S         = s_r;
  assign out_valid = valid_r;

endmodule : left_l_shifter

// File: tb/tb_left_l_shifter.sv
// Self-checking bench for left_l_shifter (either build of LLS_SHAMT_MASK_EN).
module tb_left_l_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] S;
  logic        out_valid;

  int          checks;
  int          failures;
  logic [31:0] exp_s;
  logic        exp_v;

  left_l_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .S        (S),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: A * 2^amount truncated to 32 bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    int unsigned amt;
`ifdef LLS_SHAMT_MASK_EN
    amt = b % 32;
`else
    if (b >= 32'd32) return 32'h0000_0000;
    amt = b;
`endif
    prod = {32'h0, a} * (64'd1 << amt);
    return prod[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check just after the rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    if (v) exp_s = ref_shift(a, b);
    exp_v = v;
    chk("S", S, exp_s);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
  endtask

  initial begin
    logic [31:0] ones_b [4];
    logic [31:0] ones_e [4];
    checks   = 0;
    failures = 0;
    exp_s    = 32'h0;
    exp_v    = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 32'h0;
    B        = 32'h0;

    // Reset state, including an edge with in_valid high while in reset.
    #1;
    chk("reset_S", S, 32'h0);
    chk("reset_valid", {31'd0, out_valid}, 32'h0);
    in_valid = 1'b1;
    A        = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("reset_hold_S", S, 32'h0);
    chk("reset_hold_valid", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Walking one, back-to-back.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 32'h1, i);
      chk("walk_const", S, 32'h1 << i);
    end

    // All-ones corner amounts.
    ones_b = '{32'd0, 32'd1, 32'd16, 32'd31};
    ones_e = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_0000, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hFFFF_FFFF, ones_b[i]);
      chk("ones_const", S, ones_e[i]);
    end

    // Out-of-range amounts.
    step(1'b1, 32'hDEAD_BEEF, 32'd32);
`ifdef LLS_SHAMT_MASK_EN
    chk("oor_32", S, 32'hDEAD_BEEF);
`else
    chk("oor_32", S, 32'h0);
`endif
    step(1'b1, 32'hDEAD_BEEF, 32'h8000_0001);
`ifdef LLS_SHAMT_MASK_EN
    chk("oor_hi", S, 32'hBD5B_7DDE);
`else
    chk("oor_hi", S, 32'h0);
`endif

    // Load then hold for three idle cycles.
    step(1'b1, 32'h1234_5678, 32'd4);
    chk("hold_load", S, 32'h2345_6780);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom, $urandom);
      chk("hold_keep", S, 32'h2345_6780);
    end

    // Asynchronous reset right after a capture.
    step(1'b1, 32'h0000_00F0, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_s = 32'h0;
    exp_v = 1'b0;
    chk("async_S", S, 32'h0);
    chk("async_valid", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b1;
    A        = 32'h5555_5555;
    B        = 32'd1;
    @(posedge clk);
    #1;
    chk("inflight_S", S, 32'h0);
    chk("inflight_valid", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 32'h0);

    // Random traffic with random valid and a mix of amount ranges.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] rb;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = rb & 32'h1F;
        1:       rb = rb & 32'h3F;
        default: rb = rb;
      endcase
      step(1'($urandom_range(0, 1)), $urandom, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_left_l_shifter
